regfile: RTL

- Register-file responder at the far end of the `i_fetch_rreg` read interface; the decode stage is the master on that interface.
- Holds the 32×32-bit MIPS general-purpose registers plus the HI/LO pair.
- Serves two combinational read ports and accepts one GPR write-back and one HI/LO write-back per clock from the WB stage.
- Write-through bypass: decode sees a value in the same cycle WB presents it for writing.

---
 rtl/regfile_if.sv | 51 +++++
 rtl/regfile.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg / i_fetch_rreg
// Purpose : Shared types for the register file and the decode-side read
//           interface it responds on.
//           i_fetch_rreg carries two read requests (r1_info, r2_info, each
//           {en, addr[4:0]}) from the decode stage (master) and returns
//           r1_data / r2_data [31:0] from the register file (slave).
// Revision: 1.0 - initial release
// ============================================================================

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE  = 1'b1;
  localparam reset_status_t RST_DISABLE = 1'b0;

  localparam logic REG_ENABLE  = 1'b1;
  localparam logic REG_DISABLE = 1'b0;

  // Read request: one per read port.
  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
  } reg_info_t;

  // GPR write-back from the WB stage.
  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_t;

endpackage

interface i_fetch_rreg;
  import regfile_pkg::*;

  reg_info_t             r1_info;
  reg_info_t             r2_info;
  logic [REG_DATA_W-1:0] r1_data;
  logic [REG_DATA_W-1:0] r2_data;

  modport master (output r1_info, output r2_info, input  r1_data, input  r2_data);
  modport slave  (input  r1_info, input  r2_info, output r1_data, output r2_data);
endinterface

`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module  : regfile
// Purpose : MIPS general-purpose register file (32 x 32-bit, $0 hard-wired
//           to zero) plus the HI/LO pair, with write-through bypass of the
//           WB-stage write so decode sees a value in the cycle it is written.
// Ports   : clk          - rising-edge clock
//           rst          - synchronous active-high reset (RST_ENABLE)
//           fetch        - i_fetch_rreg slave: two combinational read ports
//           wb_wreg_i    - GPR write-back {en, addr, data}
//           wb_hilo_en_i - HI/LO write enable (HI and LO written together)
//           wb_hi_i      - HI write data
//           wb_lo_i      - LO write data
//           hi_o / lo_o  - current HI / LO, bypassed from the WB write
// Revision: 1.0 - initial release
// ============================================================================

module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  reset_status_t     rst,
  i_fetch_rreg.slave        fetch,
  input  reg_t              wb_wreg_i,
  input  logic              wb_hilo_en_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int c_ADDR_W = $clog2(REG_NUM);
  localparam int c_NPORTS = 2;

  // Flattened view of the architectural registers; entry 0 is a constant.
  logic [DATA_W-1:0] w_gpr [REG_NUM];

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  reg_info_t         w_info  [c_NPORTS];
  logic [DATA_W-1:0] w_rdata [c_NPORTS];

  // --------------------------------------------------------------------------
  // GPR storage. $0 has no flop; a write aimed at it matches no entry.
  // --------------------------------------------------------------------------
  assign w_gpr[0] = '0;

  for (genvar i = 1; i < REG_NUM; i++) begin : g_gpr
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
        r_q <= '0;
      end else if (wb_wreg_i.en == REG_ENABLE &&
                   wb_wreg_i.addr == c_ADDR_W'(i)) begin
        r_q <= wb_wreg_i.data;
      end
    end

    assign w_gpr[i] = r_q;
  end

  // --------------------------------------------------------------------------
  // HI/LO pair, always written together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (wb_hilo_en_i) begin
      r_hi <= wb_hi_i;
      r_lo <= wb_lo_i;
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst != RST_ENABLE) begin
      hi_o = wb_hilo_en_i ? wb_hi_i : r_hi;
      lo_o = wb_hilo_en_i ? wb_lo_i : r_lo;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. The addr==0 test sits above the bypass so a write to $0
  // can never leak through to a reader.
  // --------------------------------------------------------------------------
  assign w_info[0] = fetch.r1_info;
  assign w_info[1] = fetch.r2_info;

  for (genvar p = 0; p < c_NPORTS; p++) begin : g_rport
    always_comb begin
      w_rdata[p] = '0;
      if (rst == RST_ENABLE) begin
        w_rdata[p] = '0;
      end else if (w_info[p].en == REG_DISABLE) begin
        w_rdata[p] = '0;
      end else if (w_info[p].addr == '0) begin
        w_rdata[p] = '0;
      end else if (wb_wreg_i.en == REG_ENABLE &&
                   wb_wreg_i.addr == w_info[p].addr) begin
        w_rdata[p] = wb_wreg_i.data;
      end else begin
        w_rdata[p] = w_gpr[w_info[p].addr];
      end
    end
  end

  assign fetch.r1_data = w_rdata[0];
  assign fetch.r2_data = w_rdata[1];

endmodule

`default_nettype wire
